// File: rtl/m_pcpi_arbiter_if.sv
// Bundle of two PCPI-style requester ports, the shared M-unit port and the watchdog flag.
// The arbiter uses the slave modport; requesters and the M-unit model use master.
interface m_pcpi_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_insn;
    logic [31:0] req0_rs1;
    logic [31:0] req0_rs2;
    logic        req0_ready;
    logic        req0_wr;
    logic [31:0] req0_rd;
    logic        req0_wait;

    logic        req1_valid;
    logic [31:0] req1_insn;
    logic [31:0] req1_rs1;
    logic [31:0] req1_rs2;
    logic        req1_ready;
    logic        req1_wr;
    logic [31:0] req1_rd;
    logic        req1_wait;

    logic        m_valid;
    logic [31:0] m_insn;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_ready;
    logic        m_wr;
    logic [31:0] m_rd;
    logic        m_busy;

    logic        timeout_err;

    modport slave (
        input  req0_valid, req0_insn, req0_rs1, req0_rs2,
        output req0_ready, req0_wr, req0_rd, req0_wait,
        input  req1_valid, req1_insn, req1_rs1, req1_rs2,
        output req1_ready, req1_wr, req1_rd, req1_wait,
        output m_valid, m_insn, m_rs1, m_rs2,
        input  m_ready, m_wr, m_rd, m_busy,
        output timeout_err
    );

    modport master (
        output req0_valid, req0_insn, req0_rs1, req0_rs2,
        input  req0_ready, req0_wr, req0_rd, req0_wait,
        output req1_valid, req1_insn, req1_rs1, req1_rs2,
        input  req1_ready, req1_wr, req1_rd, req1_wait,
        input  m_valid, m_insn, m_rs1, m_rs2,
        output m_ready, m_wr, m_rd, m_busy,
        input  timeout_err
    );
endinterface

// File: rtl/m_pcpi_arbiter.sv
// Round-robin arbiter/sequencer sharing one M-extension unit between two PCPI requesters,
// with operand latching, result capture and a watchdog that frees a silent unit.
module m_pcpi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset,
    m_pcpi_arbiter_if.slave pcpi_io
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            grant_q, grant_d;
    logic [1:0]      guard_q, guard_d;
    logic            terr_q, terr_d;
    logic            mvalid_q, mvalid_d;
    logic [31:0]     insn_q, insn_d;
    logic [31:0]     rs1_q, rs1_d;
    logic [31:0]     rs2_q, rs2_d;
    logic            wr_q, wr_d;
    logic [31:0]     rd_q, rd_d;

    logic claim0, claim1, elig0, elig1, pick1, resp0, resp1;

    assign claim0 = (pcpi_io.req0_insn[6:0] == 7'b0110011) &&
                    (pcpi_io.req0_insn[31:25] == 7'b0000001);
    assign claim1 = (pcpi_io.req1_insn[6:0] == 7'b0110011) &&
                    (pcpi_io.req1_insn[31:25] == 7'b0000001);
    assign elig0  = pcpi_io.req0_valid & claim0 & ~guard_q[0];
    assign elig1  = pcpi_io.req1_valid & claim1 & ~guard_q[1];
    // On a tie the requester that did not win last time goes first.
    assign pick1  = elig1 & (~elig0 | ~last_q);
    assign resp0  = (state_q == StResp) & ~grant_q;
    assign resp1  = (state_q == StResp) & grant_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        guard_d  = 2'b00;
        terr_d   = terr_q;
        mvalid_d = mvalid_q;
        insn_d   = insn_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        wr_d     = wr_q;
        rd_d     = rd_q;

        case (state_q)
            StIdle: begin
                if (!pcpi_io.m_busy && (elig0 || elig1)) begin
                    grant_d  = pick1;
                    insn_d   = pick1 ? pcpi_io.req1_insn : pcpi_io.req0_insn;
                    rs1_d    = pick1 ? pcpi_io.req1_rs1  : pcpi_io.req0_rs1;
                    rs2_d    = pick1 ? pcpi_io.req1_rs2  : pcpi_io.req0_rs2;
                    mvalid_d = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (pcpi_io.m_ready) begin
                    wr_d     = pcpi_io.m_wr;
                    rd_d     = pcpi_io.m_rd;
                    mvalid_d = 1'b0;
                    state_d  = StResp;
                end else if (cnt_q == CntLast) begin
                    wr_d     = 1'b0;
                    rd_d     = '0;
                    terr_d   = 1'b1;
                    mvalid_d = 1'b0;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                last_d  = grant_q;
                // Mask the served requester's still-asserted valid for one cycle.
                guard_d = grant_q ? 2'b10 : 2'b01;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            guard_q  <= 2'b00;
            terr_q   <= 1'b0;
            mvalid_q <= 1'b0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            guard_q  <= guard_d;
            terr_q   <= terr_d;
            mvalid_q <= mvalid_d;
            insn_q   <= insn_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        pcpi_io.req0_ready  = resp0;
        pcpi_io.req0_wr     = resp0 & wr_q;
        pcpi_io.req0_rd     = resp0 ? rd_q : '0;
        pcpi_io.req0_wait   = pcpi_io.req0_valid & claim0 & ~resp0 & ~guard_q[0];
        pcpi_io.req1_ready  = resp1;
        pcpi_io.req1_wr     = resp1 & wr_q;
        pcpi_io.req1_rd     = resp1 ? rd_q : '0;
        pcpi_io.req1_wait   = pcpi_io.req1_valid & claim1 & ~resp1 & ~guard_q[1];
        pcpi_io.m_valid     = mvalid_q;
        pcpi_io.m_insn      = insn_q;
        pcpi_io.m_rs1       = rs1_q;
        pcpi_io.m_rs2       = rs2_q;
        pcpi_io.timeout_err = terr_q;
    end

endmodule

// File: tb/tb_m_pcpi_arbiter.sv
// Directed bench for m_pcpi_arbiter: a cycle table for arbitration/handshake plus
// hand-written sequences for operand stability, watchdog expiry and mid-operation reset.
module tb_m_pcpi_arbiter;

    localparam logic [31:0] MUL  = 32'h02B50533;
    localparam logic [31:0] MULH = 32'h02B51533;
    localparam logic [31:0] DIV  = 32'h02B54533;
    localparam logic [31:0] ADD  = 32'h00B50533;
    localparam int NROWS = 29;

    typedef struct {
        logic        v0, v1, mr, mw, busy;
        logic [31:0] i1, mrd;
        logic        ew0, ew1, emv, er0, er1, ewr0, ewr1;
        logic [31:0] erd0, erd1, eins, ers1, ers2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[NROWS];

    m_pcpi_arbiter_if bus();

    m_pcpi_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .pcpi_io(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] in_f, input logic [31:0] i1,
                                input logic [31:0] mrd, input logic [6:0] ex_f,
                                input logic [31:0] erd0, input logic [31:0] erd1,
                                input logic [31:0] eins, input logic [31:0] ers1,
                                input logic [31:0] ers2);
        vec_t v;
        {v.v0, v.v1, v.mr, v.mw, v.busy} = in_f;
        v.i1  = i1;
        v.mrd = mrd;
        {v.ew0, v.ew1, v.emv, v.er0, v.er1, v.ewr0, v.ewr1} = ex_f;
        v.erd0 = erd0;
        v.erd1 = erd1;
        v.eins = eins;
        v.ers1 = ers1;
        v.ers2 = ers2;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int got;
        logic mv_ok;

        // in_f = {v0,v1,m_ready,m_wr,m_busy}; ex_f = {wait0,wait1,m_valid,rdy0,rdy1,wr0,wr1}
        // Tie after reset, round robin, wr=0 result, m_busy blocking.
        tbl[0]  = mk(5'b11000, MULH, 0,  7'b1100000, 0,  0,  0,    0, 0);
        tbl[1]  = mk(5'b11000, MULH, 0,  7'b1110000, 0,  0,  MUL,  7, 6);
        tbl[2]  = mk(5'b11110, MULH, 42, 7'b1110000, 0,  0,  MUL,  7, 6);
        tbl[3]  = mk(5'b11000, MULH, 0,  7'b0101010, 42, 0,  MUL,  7, 6);
        tbl[4]  = mk(5'b00000, MULH, 0,  7'b0000000, 0,  0,  MUL,  7, 6);
        tbl[5]  = mk(5'b11000, MULH, 0,  7'b1100000, 0,  0,  MUL,  7, 6);
        tbl[6]  = mk(5'b11000, MULH, 0,  7'b1110000, 0,  0,  MULH, 3, 5);
        tbl[7]  = mk(5'b11110, MULH, 15, 7'b1110000, 0,  0,  MULH, 3, 5);
        tbl[8]  = mk(5'b11000, MULH, 0,  7'b1000101, 0,  15, MULH, 3, 5);
        tbl[9]  = mk(5'b11000, MULH, 0,  7'b1000000, 0,  0,  MULH, 3, 5);
        tbl[10] = mk(5'b10000, MULH, 0,  7'b1010000, 0,  0,  MUL,  7, 6);
        tbl[11] = mk(5'b10100, MULH, 99, 7'b1010000, 0,  0,  MUL,  7, 6);
        tbl[12] = mk(5'b10000, MULH, 0,  7'b0001000, 99, 0,  MUL,  7, 6);
        tbl[13] = mk(5'b01001, MULH, 0,  7'b0100000, 0,  0,  MUL,  7, 6);
        tbl[14] = mk(5'b01001, MULH, 0,  7'b0100000, 0,  0,  MUL,  7, 6);
        tbl[15] = mk(5'b01000, MULH, 0,  7'b0100000, 0,  0,  MUL,  7, 6);
        tbl[16] = mk(5'b01000, MULH, 0,  7'b0110000, 0,  0,  MULH, 3, 5);
        tbl[17] = mk(5'b01110, MULH, 15, 7'b0110000, 0,  0,  MULH, 3, 5);
        tbl[18] = mk(5'b00000, MULH, 0,  7'b0000101, 0,  15, MULH, 3, 5);
        tbl[19] = mk(5'b00000, MULH, 0,  7'b0000000, 0,  0,  MULH, 3, 5);
        // Single MUL with a non-M instruction on req1; late m_ready in IDLE ignored.
        tbl[20] = mk(5'b11000, ADD,  0,  7'b1000000, 0,  0,  MULH, 3, 5);
        tbl[21] = mk(5'b11000, ADD,  0,  7'b1010000, 0,  0,  MUL,  7, 6);
        tbl[22] = mk(5'b11000, ADD,  0,  7'b1010000, 0,  0,  MUL,  7, 6);
        tbl[23] = mk(5'b11110, ADD,  42, 7'b1010000, 0,  0,  MUL,  7, 6);
        tbl[24] = mk(5'b11000, ADD,  0,  7'b0001010, 42, 0,  MUL,  7, 6);
        tbl[25] = mk(5'b01000, ADD,  0,  7'b0000000, 0,  0,  MUL,  7, 6);
        tbl[26] = mk(5'b01000, ADD,  0,  7'b0000000, 0,  0,  MUL,  7, 6);
        tbl[27] = mk(5'b01100, ADD,  5,  7'b0000000, 0,  0,  MUL,  7, 6);
        tbl[28] = mk(5'b01000, ADD,  0,  7'b0000000, 0,  0,  MUL,  7, 6);

        reset = 1'b1;
        bus.req0_valid = 0; bus.req0_insn = MUL; bus.req0_rs1 = 7; bus.req0_rs2 = 6;
        bus.req1_valid = 0; bus.req1_insn = MULH; bus.req1_rs1 = 3; bus.req1_rs2 = 5;
        bus.m_ready = 0; bus.m_wr = 0; bus.m_rd = 0; bus.m_busy = 0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset m_valid", {31'd0, bus.m_valid}, 0);
        chk("reset m_insn", bus.m_insn, 0);
        chk("reset m_rs1", bus.m_rs1, 0);
        chk("reset m_rs2", bus.m_rs2, 0);
        chk("reset timeout_err", {31'd0, bus.timeout_err}, 0);
        chk("reset ready/wr", {28'd0, bus.req0_ready, bus.req1_ready, bus.req0_wr, bus.req1_wr},
            0);
        chk("reset rd0", bus.req0_rd, 0);
        chk("reset rd1", bus.req1_rd, 0);

        for (int i = 0; i < NROWS; i++) begin
            tick();
            bus.req0_valid = tbl[i].v0;
            bus.req1_valid = tbl[i].v1;
            bus.req1_insn  = tbl[i].i1;
            bus.m_ready    = tbl[i].mr;
            bus.m_wr       = tbl[i].mw;
            bus.m_rd       = tbl[i].mrd;
            bus.m_busy     = tbl[i].busy;
            @(negedge clk);
            chk($sformatf("row%0d flags", i),
                {25'd0, bus.req0_wait, bus.req1_wait, bus.m_valid, bus.req0_ready,
                 bus.req1_ready, bus.req0_wr, bus.req1_wr},
                {25'd0, tbl[i].ew0, tbl[i].ew1, tbl[i].emv, tbl[i].er0, tbl[i].er1,
                 tbl[i].ewr0, tbl[i].ewr1});
            chk($sformatf("row%0d rd0", i), bus.req0_rd, tbl[i].erd0);
            chk($sformatf("row%0d rd1", i), bus.req1_rd, tbl[i].erd1);
            chk($sformatf("row%0d m_insn", i), bus.m_insn, tbl[i].eins);
            chk($sformatf("row%0d m_rs1", i), bus.m_rs1, tbl[i].ers1);
            chk($sformatf("row%0d m_rs2", i), bus.m_rs2, tbl[i].ers2);
        end
        chk("timeout_err after table", {31'd0, bus.timeout_err}, 0);

        // Operands move every cycle after the grant; latched copies must not.
        tick();
        bus.req1_valid = 0; bus.m_ready = 0; bus.m_busy = 0;
        bus.req0_valid = 1; bus.req0_insn = MUL; bus.req0_rs1 = 100; bus.req0_rs2 = 200;
        @(negedge clk);
        chk("stab wait0", {31'd0, bus.req0_wait}, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.req0_rs1 = 100 + k;
            bus.req0_rs2 = 200 + k;
            bus.m_ready  = (k == 3);
            bus.m_wr     = 1;
            bus.m_rd     = 77;
            @(negedge clk);
            chk($sformatf("stab m_rs1 k%0d", k), bus.m_rs1, 100);
            chk($sformatf("stab m_rs2 k%0d", k), bus.m_rs2, 200);
        end
        chk("stab ready0", {31'd0, bus.req0_ready}, 1);
        chk("stab rd0", bus.req0_rd, 77);
        tick();
        bus.req0_valid = 0; bus.m_ready = 0;

        // Watchdog: unit never answers.
        tick();
        bus.req0_valid = 1; bus.req0_insn = DIV; bus.req0_rs1 = 1000; bus.req0_rs2 = 3;
        @(negedge clk);
        chk("to wait0", {31'd0, bus.req0_wait}, 1);
        got = 0;
        mv_ok = 1'b1;
        for (int k = 1; k <= 80 && got == 0; k++) begin
            tick();
            bus.m_busy = 1;
            @(negedge clk);
            if (bus.req0_ready) got = k;
            else if (!bus.m_valid) mv_ok = 1'b0;
        end
        chk("to latency", got, 66);
        chk("to m_valid held", {31'd0, mv_ok}, 1);
        chk("to wr0", {31'd0, bus.req0_wr}, 0);
        chk("to rd0", bus.req0_rd, 0);
        chk("to timeout_err", {31'd0, bus.timeout_err}, 1);
        chk("to m_valid after", {31'd0, bus.m_valid}, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.m_ready = 1; bus.m_wr = 1; bus.m_rd = 55;
            @(negedge clk);
            chk($sformatf("late m_valid k%0d", k), {31'd0, bus.m_valid}, 0);
            chk($sformatf("late ready0 k%0d", k), {31'd0, bus.req0_ready}, 0);
        end
        chk("to sticky", {31'd0, bus.timeout_err}, 1);

        // Unit free again: re-grant the DIV, then reset mid-WAIT.
        tick();
        bus.m_ready = 0; bus.m_busy = 0;
        tick();
        @(negedge clk);
        chk("div issue m_valid", {31'd0, bus.m_valid}, 1);
        chk("div issue m_rs1", bus.m_rs1, 1000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("rst m_valid", {31'd0, bus.m_valid}, 0);
        chk("rst timeout_err", {31'd0, bus.timeout_err}, 0);
        chk("rst m_insn", bus.m_insn, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst no ready k%0d", k), {30'd0, bus.req0_ready, bus.req1_ready}, 0);
            chk($sformatf("rst m_valid k%0d", k), {31'd0, bus.m_valid}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
